// File: rtl/multicycle_alu.sv
// Multicycle ALU. Add/sub/shift/logic finish in one cycle; multiply is a WIDTH-cycle shift-add.
// Define MULTICYCLE_ALU_DIV_EN to build the WIDTH-cycle restoring divider (opcode 0011).
module multicycle_alu #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [3:0]       operation,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] result,
   output logic             zeroFlag,
   output logic             negFlag,
   output logic             ovfFlag,
   output logic             dbzFlag,
   output logic             illegalFlag
);

   localparam int SHAMT_W = $clog2(WIDTH);
   localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_MUL = 4'h2;
`ifdef MULTICYCLE_ALU_DIV_EN
   localparam logic [3:0] OP_DIV = 4'h3;
`endif
   localparam logic [3:0] OP_SLL = 4'h4;
   localparam logic [3:0] OP_SRL = 4'h5;
   localparam logic [3:0] OP_SRA = 4'h6;
   localparam logic [3:0] OP_AND = 4'h7;
   localparam logic [3:0] OP_OR  = 4'h8;
   localparam logic [3:0] OP_XOR = 4'h9;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
`ifdef MULTICYCLE_ALU_DIV_EN
      S_DIV  = 2'd3,
`endif
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     opa_q, opa_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 zero_q, zero_d;
   logic                 neg_q, neg_d;
   logic                 ovf_q, ovf_d;
   logic                 dbz_q, dbz_d;
   logic                 ill_q, ill_d;

   logic [WIDTH-1:0]        sum, diff, prod_nxt, res_n;
   logic signed [WIDTH-1:0] op1_s;
   logic [SHAMT_W-1:0]      shamt;
   logic                    ovf_n, dbz_n, ill_n, done_n;
`ifdef MULTICYCLE_ALU_DIV_EN
   logic [WIDTH:0]          rem_sh;
   logic [WIDTH-1:0]        rem_sub;
   logic                    rem_ge;
`endif

   // Two's-complement overflow: like-signed operands yielding a result of the other sign.
   function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      dbz_d    = dbz_q;
      ill_d    = ill_q;
      res_n    = '0;
      ovf_n    = 1'b0;
      dbz_n    = 1'b0;
      ill_n    = 1'b0;
      done_n   = 1'b0;
      sum      = operand1 + operand2;
      diff     = operand1 - operand2;
      op1_s    = operand1;
      shamt    = operand2[SHAMT_W-1:0];
      prod_nxt = opb_q[0] ? (acc_q + opa_q) : acc_q;
`ifdef MULTICYCLE_ALU_DIV_EN
      // acc holds the partial remainder; opa shifts dividend bits out and quotient bits in.
      rem_sh   = {acc_q, opa_q[WIDTH-1]};
      rem_ge   = (rem_sh >= {1'b0, opb_q});
      rem_sub  = rem_sh[WIDTH-1:0] - opb_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (inValid) begin
               opa_d  = operand1;
               opb_d  = operand2;
               acc_d  = '0;
               cnt_d  = '0;
               done_n = 1'b1;
               case (operation)
                  OP_ADD: begin
                     res_n = sum;
                     ovf_n = add_ovf(operand1[WIDTH-1], operand2[WIDTH-1], sum[WIDTH-1]);
                  end
                  OP_SUB: begin
                     res_n = diff;
                     ovf_n = add_ovf(operand1[WIDTH-1], ~operand2[WIDTH-1], diff[WIDTH-1]);
                  end
                  OP_MUL: begin
                     done_n  = 1'b0;
                     state_d = S_MUL;
                  end
`ifdef MULTICYCLE_ALU_DIV_EN
                  OP_DIV: begin
                     if (operand2 == '0) begin
                        res_n = '1;
                        dbz_n = 1'b1;
                     end else begin
                        done_n  = 1'b0;
                        state_d = S_DIV;
                     end
                  end
`endif
                  OP_SLL:  res_n = operand1 << shamt;
                  OP_SRL:  res_n = operand1 >> shamt;
                  OP_SRA:  res_n = op1_s >>> shamt;
                  OP_AND:  res_n = operand1 & operand2;
                  OP_OR:   res_n = operand1 | operand2;
                  OP_XOR:  res_n = operand1 ^ operand2;
                  default: ill_n = 1'b1;
               endcase
            end
         end
         S_MUL: begin
            acc_d = prod_nxt;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
            cnt_d = cnt_q + SHAMT_W'(1);
            if (cnt_q == CNT_LAST) begin
               res_n  = prod_nxt;
               done_n = 1'b1;
            end
         end
`ifdef MULTICYCLE_ALU_DIV_EN
         S_DIV: begin
            acc_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], rem_ge};
            cnt_d = cnt_q + SHAMT_W'(1);
            if (cnt_q == CNT_LAST) begin
               res_n  = {opa_q[WIDTH-2:0], rem_ge};
               done_n = 1'b1;
            end
         end
`endif
         S_DONE: begin
            if (outReady) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Result and flags only change when an operation completes; they persist after DONE.
      if (done_n) begin
         state_d  = S_DONE;
         cnt_d    = '0;
         result_d = res_n;
         zero_d   = (res_n == '0);
         neg_d    = res_n[WIDTH-1];
         ovf_d    = ovf_n;
         dbz_d    = dbz_n;
         ill_d    = ill_n;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         dbz_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
         dbz_q    <= dbz_d;
         ill_q    <= ill_d;
      end
   end

   assign inReady     = (state_q == S_IDLE);
   assign outValid    = (state_q == S_DONE);
   assign result      = result_q;
   assign zeroFlag    = zero_q;
   assign negFlag     = neg_q;
   assign ovfFlag     = ovf_q;
   assign dbzFlag     = dbz_q;
   assign illegalFlag = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=64): directed cases, handshake/reset scenarios,
// and random operations scored against a behavioural model. Flags are packed {zero,neg,ovf,dbz,ill}.
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        inValid;
   logic        inReady;
   logic [3:0]  operation;
   logic [63:0] operand1;
   logic [63:0] operand2;
   logic        outValid;
   logic        outReady;
   logic [63:0] result;
   logic        zeroFlag, negFlag, ovfFlag, dbzFlag, illegalFlag;

   int n_checks = 0;
   int n_pass   = 0;

   multicycle_alu #(.WIDTH(64)) dut (
      .clk(clk), .reset_n(reset_n), .inValid(inValid), .inReady(inReady),
      .operation(operation), .operand1(operand1), .operand2(operand2),
      .outValid(outValid), .outReady(outReady), .result(result),
      .zeroFlag(zeroFlag), .negFlag(negFlag), .ovfFlag(ovfFlag),
      .dbzFlag(dbzFlag), .illegalFlag(illegalFlag)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

   function automatic logic [4:0] flags_now();
      return {zeroFlag, negFlag, ovfFlag, dbzFlag, illegalFlag};
   endfunction

   // Behavioural reference computed from the opcode rules with plain 64-bit arithmetic.
   function automatic void ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                     output logic [63:0] r, output logic [4:0] f, output int lat);
      longint sa, sb, sr;
      logic ovf, dbz, ill;
      ovf = 1'b0; dbz = 1'b0; ill = 1'b0; lat = 1; r = '0;
      sa = a; sb = b;
      case (op)
         4'h0: begin r = a + b; sr = r; ovf = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0)); end
         4'h1: begin r = a - b; sr = r; ovf = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0)); end
         4'h2: begin r = a * b; lat = 65; end
`ifdef MULTICYCLE_ALU_DIV_EN
         4'h3: begin
            if (b == 0) begin r = {64{1'b1}}; dbz = 1'b1; end
            else begin r = a / b; lat = 65; end
         end
`endif
         4'h4: r = a << b[5:0];
         4'h5: r = a >> b[5:0];
         4'h6: r = $signed(a) >>> b[5:0];
         4'h7: r = a & b;
         4'h8: r = a | b;
         4'h9: r = a ^ b;
         default: ill = 1'b1;
      endcase
      if (ill) r = '0;
      f = {(r == 0), r[63], ovf, dbz, ill};
   endfunction

   // Issue one request, scramble inputs after accept, wait (bounded) for outValid, then drain.
   task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic [4:0] f, output int lat, output int rdy_err);
      rdy_err = 0;
      operation = op; operand1 = a; operand2 = b; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      operation = 4'($urandom);
      operand1 = {$urandom, $urandom};
      operand2 = {$urandom, $urandom};
      lat = 1;
      while (!outValid && lat < 200) begin
         if (inReady) rdy_err++;
         @(posedge clk); #1;
         lat++;
      end
      r = result;
      f = flags_now();
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; inValid = 1'b0; outReady = 1'b0;
      operation = '0; operand1 = '0; operand2 = '0;
      #3;
      n_checks++;
      if (inReady !== 1'b1) $display("FAIL reset_inready: got %b want 1", inReady); else n_pass++;
      n_checks++;
      if (outValid !== 1'b0) $display("FAIL reset_outvalid: got %b want 0", outValid); else n_pass++;
      n_checks++;
      if (result !== 64'h0) $display("FAIL reset_result: got %h want 0", result); else n_pass++;
      n_checks++;
      if (flags_now() !== 5'b0) $display("FAIL reset_flags: got %b want 00000", flags_now()); else n_pass++;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({inReady, outValid} !== 2'b10)
         $display("FAIL post_reset_handshake: got inReady,outValid=%b want 10", {inReady, outValid});
      else n_pass++;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] r;
      logic [4:0]  f;
      int          lat;
   } vec_t;

   task automatic test_directed();
      vec_t tbl [10];
      logic [63:0] r;
      logic [4:0]  f;
      int lat, rdy_err;
      tbl[0] = '{4'h0, 64'hFFFF, 64'h2, 64'h10001, 5'b00000, 1};
      tbl[1] = '{4'h1, 64'h5, 64'h5, 64'h0, 5'b10000, 1};
      tbl[2] = '{4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 5'b01100, 1};
      tbl[3] = '{4'h2, 64'hF, 64'h10, 64'hF0, 5'b00000, 65};
`ifdef MULTICYCLE_ALU_DIV_EN
      tbl[4] = '{4'h3, 64'hFFFF, 64'h0F0F, 64'h11, 5'b00000, 65};
      tbl[5] = '{4'h3, 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'b01010, 1};
`else
      tbl[4] = '{4'h3, 64'hFFFF, 64'h0F0F, 64'h0, 5'b10001, 1};
      tbl[5] = '{4'h3, 64'h10, 64'h0, 64'h0, 5'b10001, 1};
`endif
      tbl[6] = '{4'hF, 64'h1234, 64'h5678, 64'h0, 5'b10001, 1};
      tbl[7] = '{4'h1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 5'b00100, 1};
      tbl[8] = '{4'h5, 64'h8000_0000_0000_0000, 64'hFF, 64'h1, 5'b00000, 1};
      tbl[9] = '{4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 64'hFFFF_FFFF_FFFF_FFFD, 5'b01000, 65};
      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, f, lat, rdy_err);
         n_checks++;
         if (r !== tbl[i].r) $display("FAIL dir%0d_result: got %h want %h", i, r, tbl[i].r); else n_pass++;
         n_checks++;
         if (f !== tbl[i].f) $display("FAIL dir%0d_flags: got %b want %b", i, f, tbl[i].f); else n_pass++;
         n_checks++;
         if (lat !== tbl[i].lat) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tbl[i].lat); else n_pass++;
         n_checks++;
         if (rdy_err !== 0) $display("FAIL dir%0d_inready_busy: got %0d high cycles want 0", i, rdy_err); else n_pass++;
      end
   endtask

   task automatic test_hold_and_drain();
      operation = 4'h6; operand1 = 64'h8000_0000_0000_0000; operand2 = 64'h44; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0; operand1 = '0; operand2 = '0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({outValid, inReady} !== 2'b10 || result !== 64'hF800_0000_0000_0000 || flags_now() !== 5'b01000)
            $display("FAIL hold_cycle%0d: got v,r=%b%b res=%h flags=%b want 10 f800000000000000 01000",
                     i, outValid, inReady, result, flags_now());
         else n_pass++;
         if (i < 2) begin @(posedge clk); #1; end
      end
      // Drain while a new request waits: it must not be accepted on the drain edge.
      outReady = 1'b1; inValid = 1'b1; operation = 4'h0; operand1 = 64'h1; operand2 = 64'h2;
      @(posedge clk); #1;
      n_checks++;
      if ({outValid, inReady} !== 2'b01 || result !== 64'hF800_0000_0000_0000)
         $display("FAIL drain_no_accept: got v,r=%b%b res=%h want 01 f800000000000000", outValid, inReady, result);
      else n_pass++;
      @(posedge clk); #1;
      inValid = 1'b0;
      n_checks++;
      if (outValid !== 1'b1 || result !== 64'h3)
         $display("FAIL accept_after_drain: got v=%b res=%h want 1 3", outValid, result);
      else n_pass++;
      @(posedge clk); #1;
      outReady = 1'b0;
      n_checks++;
      if ({outValid, inReady} !== 2'b01) $display("FAIL second_drain: got v,r=%b%b want 01", outValid, inReady); else n_pass++;
   endtask

   task automatic test_reset_mid_mul();
      logic [63:0] r;
      logic [4:0]  f;
      int lat, rdy_err, stray;
      run_op(4'h0, 64'h3, 64'h4, r, f, lat, rdy_err);
      operation = 4'h2; operand1 = 64'hDEAD_BEEF; operand2 = 64'h1234_5678; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      repeat (19) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({outValid, inReady} !== 2'b01 || result !== 64'h0 || flags_now() !== 5'b0)
         $display("FAIL midmul_reset: got v,r=%b%b res=%h flags=%b want 01 0 00000", outValid, inReady, result, flags_now());
      else n_pass++;
      @(posedge clk); #1;
      reset_n = 1'b1;
      stray = 0;
      repeat (70) begin
         @(posedge clk); #1;
         if (outValid || !inReady) stray++;
      end
      n_checks++;
      if (stray !== 0) $display("FAIL midmul_aborted: got %0d busy cycles want 0", stray); else n_pass++;
      run_op(4'h0, 64'h1, 64'h1, r, f, lat, rdy_err);
      n_checks++;
      if (r !== 64'h2 || f !== 5'b0) $display("FAIL post_reset_add: got %h/%b want 2/00000", r, f); else n_pass++;
      n_checks++;
      if (lat !== 1) $display("FAIL post_reset_add_latency: got %0d want 1", lat); else n_pass++;
   endtask

   function automatic logic [63:0] pick_operand(input int sel);
      case (sel)
         0: return 64'($urandom_range(0, 20));
         1: return {$urandom, $urandom};
         2: return 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 7));
         default: return 64'h7FFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   task automatic test_random();
      logic [3:0]  op;
      logic [63:0] a, b, r, er;
      logic [4:0]  f, ef;
      int lat, elat, rdy_err;
      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         a  = pick_operand($urandom_range(0, 3));
         b  = ($urandom_range(0, 7) == 0) ? 64'h0 : pick_operand($urandom_range(0, 3));
         ref_model(op, a, b, er, ef, elat);
         run_op(op, a, b, r, f, lat, rdy_err);
         n_checks++;
         if (r !== er) $display("FAIL rnd%0d_result op=%h a=%h b=%h: got %h want %h", i, op, a, b, r, er); else n_pass++;
         n_checks++;
         if (f !== ef) $display("FAIL rnd%0d_flags op=%h: got %b want %b", i, op, f, ef); else n_pass++;
         n_checks++;
         if (lat !== elat || rdy_err !== 0)
            $display("FAIL rnd%0d_timing op=%h: got lat %0d busy-ready %0d want lat %0d busy-ready 0", i, op, lat, rdy_err, elat);
         else n_pass++;
         n_checks++;
         if ({outValid, inReady} !== 2'b01 || result !== er || flags_now() !== ef)
            $display("FAIL rnd%0d_after_drain: got v,r=%b%b res=%h flags=%b want 01 %h %b",
                     i, outValid, inReady, result, flags_now(), er, ef);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold_and_drain();
      test_reset_mid_mul();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
